embedded_soc_pio_shift_out: RTL



---
 rtl/embedded_soc_pio_pkg.sv | 14 +
 rtl/embedded_soc_pio_shift_tick.sv | 34 +++
 rtl/embedded_soc_pio_shift_out.sv | 117 +++++++++++
 3 files changed

// File: rtl/embedded_soc_pio_pkg.sv
// Shared types and default sizing for the PIO serial shift-out path.
package embedded_soc_pio_pkg;

   localparam int PIO_SHIFT_DATA_WIDTH = 32;
   localparam int PIO_SHIFT_CLK_DIV    = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } pio_shift_state_t;

endpackage

// File: rtl/embedded_soc_pio_shift_tick.sv
// Half-period timer: counts 0..CLK_DIV-1 and wraps, with a synchronous clear.
module embedded_soc_pio_shift_tick
   import embedded_soc_pio_pkg::*;
#(
   parameter int CLK_DIV = PIO_SHIFT_CLK_DIV
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   output logic tc_o,
   output logic tc_next_o
);

   localparam int CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] TC_VAL = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || tc_o) cnt_d = '0;
   end

   // Lets the owner register a flag that lines up with the terminal cycle.
   assign tc_next_o = (cnt_d == TC_VAL);

   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/embedded_soc_pio_shift_out.sv
// Serialises the PIO word MSB-first to a 74HC595-style chain whenever it changes.
module embedded_soc_pio_shift_out
   import embedded_soc_pio_pkg::*;
#(
   parameter int DATA_WIDTH = PIO_SHIFT_DATA_WIDTH,
   parameter int CLK_DIV    = PIO_SHIFT_CLK_DIV
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] pio_word,
   input  logic                  resend,
   output logic                  ser_data,
   output logic                  ser_clk,
   output logic                  ser_latch,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   pio_shift_state_t      state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  pending_q, pending_d;
   logic                  ser_data_q, ser_clk_q, ser_latch_q, busy_q, frame_done_q;
   logic                  tc, tc_next, start, idle;

   assign idle  = (state_q == IDLE);
   assign start = (pio_word != shadow_q) || pending_q || resend;

   embedded_soc_pio_shift_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk_i    (clk),
      .reset_i  (reset),
      .clr_i    (idle),
      .tc_o     (tc),
      .tc_next_o(tc_next)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      shadow_d  = shadow_q;
      bit_d     = bit_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d   = pio_word;
               shadow_d  = pio_word;
               pending_d = 1'b0;
               bit_d     = '0;
               state_d   = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (tc) state_d = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (tc) begin
               shift_d = shift_q << 1;
               bit_d   = bit_q + BW'(1);
               state_d = (bit_q == LAST_BIT) ? LATCH : SHIFT_LO;
            end
         end
         LATCH: begin
            if (tc) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Any number of resends during a frame collapse into one follow-up frame.
      if (!idle && resend) pending_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         shadow_q  <= '0;
         bit_q     <= '0;
         pending_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         shadow_q  <= shadow_d;
         bit_q     <= bit_d;
         pending_q <= pending_d;
      end
   end

   // Outputs are registered from next-state so they align with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         ser_data_q   <= 1'b0;
         ser_clk_q    <= 1'b0;
         ser_latch_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         ser_data_q   <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && shift_d[DATA_WIDTH-1];
         ser_clk_q    <= (state_d == SHIFT_HI);
         ser_latch_q  <= (state_d == LATCH);
         busy_q       <= (state_d != IDLE);
         frame_done_q <= (state_d == LATCH) && tc_next;
      end
   end

   assign ser_data   = ser_data_q;
   assign ser_clk    = ser_clk_q;
   assign ser_latch  = ser_latch_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
